// File: rtl/demux_rr_scheduler_pkg.sv
// Shared types, sizes and the round-robin pick for the 1x8 demux scheduler.
package demux_sched_pkg;

  localparam int unsigned N_DST = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // First set bit of elig scanning circularly from last+1; 'last' itself is checked last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_DST-1:0] elig,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= N_DST; i++) begin
      idx = last + SEL_W'(i);
      if (!found && elig[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/demux_rr_scheduler_if.sv
// Producer/consumer handshake bundle for the round-robin demux scheduler.
interface demux_rr_scheduler_if #(
  parameter int unsigned DW = 1
);
  import demux_sched_pkg::*;

  logic                  en;
  logic [N_DST-1:0]      dst_mask;
  logic [N_DST-1:0]      dst_ready;
  logic                  in_valid;
  logic [DW-1:0]         in_data;
  logic                  in_ready;
  logic [SEL_W-1:0]      sel;
  logic [N_DST-1:0]      out_valid;
  logic [N_DST*DW-1:0]   out_data;
  logic                  busy;
  logic                  burst_done;

  modport master (
    output en, dst_mask, dst_ready, in_valid, in_data,
    input  in_ready, sel, out_valid, out_data, busy, burst_done
  );

  modport slave (
    input  en, dst_mask, dst_ready, in_valid, in_data,
    output in_ready, sel, out_valid, out_data, busy, burst_done
  );

endinterface

// File: rtl/demux_rr_scheduler_data.sv
// Combinational 1-to-8 data/valid demux; everything is zero while not enabled.
module demux_1x8_data
  import demux_sched_pkg::*;
#(
  parameter int unsigned DW = 1
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic [N_DST-1:0]    out_valid,
  output logic [N_DST*DW-1:0] out_data
);

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    if (en) begin
      out_valid[sel]          = in_valid;
      out_data[sel*DW +: DW]  = in_data;
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler: grants one input stream to one of eight sinks
// for BURST beats at a time and owns the registered demux select.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned DW    = 1,
  parameter int unsigned BURST = 4
) (
  input logic                 clk,
  input logic                 rst,
  demux_rr_scheduler_if.slave bus
);

  localparam int unsigned       CNT_W     = $clog2(BURST) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [SEL_W-1:0] last_q, last_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             done_q, done_n;
  logic [N_DST-1:0] eligible;
  logic             xfer;
  logic             abort;
  logic             serving;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= '0;
      last_q <= '1;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sel_q  <= sel_n;
      last_q <= last_n;
      cnt_q  <= cnt_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel_q;
    last_n   = last_q;
    cnt_n    = cnt_q;
    done_n   = 1'b0;
    eligible = bus.dst_mask & bus.dst_ready;
    xfer     = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && (|eligible)) begin
          sel_n   = rr_pick(eligible, last_q);
          cnt_n   = '0;
          state_n = SERVE;
        end
      end
      SERVE: begin
        xfer  = bus.in_valid & bus.dst_ready[sel_q];
        abort = !bus.en || !bus.dst_mask[sel_q];
        // Abort wins over completion: the last beat still moves, but no done pulse.
        if (abort) begin
          last_n  = sel_q;
          state_n = IDLE;
        end else if (xfer) begin
          if (cnt_q == LAST_BEAT) begin
            last_n  = sel_q;
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign serving        = (state == SERVE);
  assign bus.busy       = serving;
  assign bus.sel        = sel_q;
  assign bus.burst_done = done_q;
  assign bus.in_ready   = serving & bus.dst_ready[sel_q];

  demux_1x8_data #(
    .DW(DW)
  ) u_data (
    .sel      (sel_q),
    .en       (serving),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .out_valid(bus.out_valid),
    .out_data (bus.out_data)
  );

endmodule

// File: doc/demux_rr_scheduler.md
# demux_rr_scheduler

Round-robin scheduler that shares one input stream among eight sinks through a 1-to-8 demultiplexer. It grants the stream to one sink at a time for a fixed-length burst, drives the demux select, and applies valid/ready handshakes on both sides. It sits between a single producer and eight consumers and owns the registered select for the 1x8 demux datapath.

## Interface
- `DW`, 1: data width per beat.
- `BURST`, 4: beats per grant (≥1).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: global enable; low blocks new grants and aborts the current one.
- `dst_mask` input 8: per-sink enable; bit i = 1 makes sink i eligible.
- `dst_ready` input 8: per-sink ready.
- `in_valid` input 1: producer has a beat.
- `in_data` input DW: producer beat.
- `in_ready` output 1: beat accepted this cycle when high together with `in_valid`.
- `sel` output 3: registered demux select (current grant).
- `out_valid` output 8: one-hot valid to the granted sink; all zero when no grant.
- `out_data` output 8*DW: slice i carries `in_data` when i == `sel` and granted; all other slices are 0.
- `busy` output 1: high in SERVE.
- `burst_done` output 1: one-cycle pulse on the cycle after the final beat of a completed burst.

## Operation
- FSM states: IDLE, SERVE.
- IDLE: eligible = `dst_mask` & `dst_ready`. If `en` and eligible ≠ 0, pick the first eligible index scanning circularly from `last`+1 (mod 8). Load `sel` with it, clear `beat_cnt`, go to SERVE. Otherwise stay in IDLE.
- SERVE:
  - `in_ready` = `dst_ready[sel]`.
  - `out_valid[sel]` = `in_valid`.
  - `out_data` slice `sel` = `in_data` (combinational demux).
  - Beat transfer = `in_valid` & `dst_ready[sel]`; each transfer increments `beat_cnt`.
  - On the transfer with `beat_cnt` == BURST-1: set `last` = `sel`, go to IDLE, pulse `burst_done` next cycle.
  - Abort: if `en` = 0 or `dst_mask[sel]` = 0, go to IDLE next cycle with no `burst_done`. `last` is set to `sel` so the aborted sink loses its turn. Beats already transferred stay delivered.
- Abort takes priority over completion when both occur in the same cycle. The final beat still transfers, but `burst_done` is suppressed.
- Deasserting `dst_ready[sel]` mid-burst stalls the burst; it does not abort.
- `last` resets to 7, so sink 0 is checked first after reset.
- Counter width: clog2(BURST)+1 bits. No wrap occurs, because the counter clears on every grant.

## Timing
- Reset values: state IDLE, `sel` = 0, `last` = 7, `beat_cnt` = 0, `in_ready` = 0, `out_valid` = 0, `out_data` = 0, `busy` = 0, `burst_done` = 0.
- Grant latency: eligibility seen in IDLE at cycle t gives SERVE, with `sel` valid, at t+1. The first beat can transfer at t+1.
- Burst of BURST beats with no stalls: grant cycle + BURST cycles. There is one IDLE bubble between consecutive bursts.
- `in_ready`, `out_valid` and `out_data` are combinational from registered state and inputs. They are 0 in IDLE.
- Reset asserted mid-burst: all outputs take their reset values on the next edge, and the partial burst is discarded.

## Structure
- Shared package `demux_sched_pkg`:
  - state enum (IDLE, SERVE)
  - `N_DST` = 8
  - `SEL_W` = 3
- Sub-module `demux_1x8_data`: combinational DW-wide 1-to-8 demux with enable. It drives `out_data` and `out_valid` from `sel`, busy and `in_valid`.
- The round-robin pick is a function in the package.

## Test plan
- Reset, then `dst_mask` = FF, `dst_ready` = FF, `in_valid` held 1, BURST = 4 → grants go 0,1,2,…,7,0. Each burst is 4 beats, `burst_done` pulses once per burst, and there is one IDLE cycle between bursts.
- `dst_mask` = 0x24 → only `sel` = 2 and `sel` = 5 are granted, alternating 2,5,2. `out_valid` never sets any other bit.
- In SERVE at `sel` = 3, drop `dst_ready[3]` for 3 cycles after beat 2 → `in_ready` = 0 for those cycles, and the burst completes with exactly 4 beats. `burst_done` is delayed by 3 cycles.
- Clear `dst_mask[sel]` after beat 1 → IDLE next cycle with no `burst_done`. The next grant goes to the next eligible index after the aborted one.
- Drive `en` low and assert `rst` mid-burst (separately) → with `en` low, IDLE and no new grants until `en` rises again. With `rst`, all outputs are 0, `sel` = 0, and the first grant after reset goes to sink 0.
- `dst_mask` = 0 or `dst_ready` = 0 with `in_valid` = 1 → stays in IDLE, `in_ready` = 0, `busy` = 0 indefinitely.
